// File: rtl/port_bank_pkg.sv
// Shared word width, address-map offsets and address decode for the port bank.
package port_bank_pkg;

   localparam int WORD_SIZE  = 16;
   // Offsets of the read-only registers, relative to the first address after the output ports.
   localparam int STATUS_OFS = 0;
   localparam int FLAG_OFS   = 1;

   typedef enum logic [1:0] {
      RGN_OUT,
      RGN_STATUS,
      RGN_FLAGS,
      RGN_NONE
   } region_e;

   function automatic region_e decode_region(input logic [31:0] addr, input logic [31:0] num_out);
      region_e rgn;
      rgn = RGN_NONE;
      if (addr < num_out) begin
         rgn = RGN_OUT;
      end else if (addr == num_out + 32'(STATUS_OFS)) begin
         rgn = RGN_STATUS;
      end else if (addr == num_out + 32'(FLAG_OFS)) begin
         rgn = RGN_FLAGS;
      end
      return rgn;
   endfunction

endpackage

// File: rtl/port_bank_if.sv
// CPU-side port bus of the port bank: address, write data, strobes and read data.
interface port_bank_if
   import port_bank_pkg::*;
#(
   parameter int WORD_SIZE = port_bank_pkg::WORD_SIZE
);
   logic [WORD_SIZE-1:0] portaddr;
   logic [WORD_SIZE-1:0] portval;
   logic                 portset;
   logic                 portget;
   logic [WORD_SIZE-1:0] portout;

   modport master (
      output portaddr,
      output portval,
      output portset,
      output portget,
      input  portout
   );

   modport slave (
      input  portaddr,
      input  portval,
      input  portset,
      input  portget,
      output portout
   );
endinterface

// File: rtl/port_bank_input_sync.sv
// Two-flop synchronizer for one button bit, with a rising-edge flag on the synchronized level.
module input_sync (
   input  logic clk,
   input  logic srst,
   input  logic async_in,
   output logic level,
   output logic rise
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
endmodule

// File: rtl/port_bank.sv
// Bank of CPU-writable output ports, button status/sticky-flag registers and a display channel mux.
module port_bank
   import port_bank_pkg::*;
#(
   parameter int WORD_SIZE = port_bank_pkg::WORD_SIZE,
   parameter int NUM_OUT   = 4,
   parameter int NUM_IN    = 4,
   localparam int SEL_W    = $clog2(NUM_OUT)
) (
   input  logic                 mclk,
   input  logic                 rst,
   port_bank_if.slave           bus,
   input  logic [NUM_IN-1:0]    btn,
   input  logic [SEL_W-1:0]     show_sel,
   output logic [WORD_SIZE-1:0] show_val,
   output logic                 show_stb
);
   logic [WORD_SIZE-1:0] regs_q [NUM_OUT];
   logic [WORD_SIZE-1:0] regs_d [NUM_OUT];
   logic [NUM_IN-1:0]    flag_q, flag_d;
   logic [WORD_SIZE-1:0] portout_q, portout_d;
   logic [WORD_SIZE-1:0] show_val_q, show_val_d;
   logic                 show_stb_q, show_stb_d;

   logic [NUM_IN-1:0]    btn_level;
   logic [NUM_IN-1:0]    btn_rise;
   region_e              region;
   logic [SEL_W-1:0]     idx;
   logic [WORD_SIZE-1:0] rd_data;
   logic                 flag_clr;
   logic                 sel_valid;

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
         input_sync u_sync (
            .clk      (mclk),
            .srst     (rst),
            .async_in (btn[gi]),
            .level    (btn_level[gi]),
            .rise     (btn_rise[gi])
         );
      end
   endgenerate

   assign region    = decode_region(32'(bus.portaddr), 32'(NUM_OUT));
   assign idx       = bus.portaddr[SEL_W-1:0];
   assign sel_valid = 32'(show_sel) < 32'(NUM_OUT);

   always_comb begin
      regs_d = regs_q;
      if (bus.portset && region == RGN_OUT) begin
         regs_d[idx] = bus.portval;
      end

      // Reads use the pre-write register contents, so a same-cycle read/write returns the old value.
      rd_data = '0;
      case (region)
         RGN_OUT:    rd_data = regs_q[idx];
         RGN_STATUS: rd_data[NUM_IN-1:0] = btn_level;
         RGN_FLAGS:  rd_data[NUM_IN-1:0] = flag_q;
         default:    rd_data = '0;
      endcase
      portout_d = bus.portget ? rd_data : portout_q;

      // A rise arriving with the clearing read survives it.
      flag_clr = bus.portget && region == RGN_FLAGS;
      flag_d   = (flag_clr ? '0 : flag_q) | btn_rise;

      show_val_d = sel_valid ? regs_q[show_sel] : '0;
      show_stb_d = show_val_d != show_val_q;
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         regs_q     <= '{default: '0};
         flag_q     <= '0;
         portout_q  <= '0;
         show_val_q <= '0;
         show_stb_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         flag_q     <= flag_d;
         portout_q  <= portout_d;
         show_val_q <= show_val_d;
         show_stb_q <= show_stb_d;
      end
   end

   assign bus.portout = portout_q;
   assign show_val    = show_val_q;
   assign show_stb    = show_stb_q;
endmodule

// File: tb/tb_port_bank.sv
// Scoreboard bench for port_bank: reads and display strobes are checked by monitors against queued expectations.
module tb_port_bank;
   localparam int WS = 16;
   localparam int NO = 4;
   localparam int NI = 4;

   logic          mclk = 1'b0;
   logic          rst  = 1'b1;
   logic [NI-1:0] btn  = '0;
   logic [1:0]    show_sel = '0;
   logic [WS-1:0] show_val;
   logic          show_stb;

   port_bank_if #(.WORD_SIZE(WS)) bus ();

   port_bank #(.WORD_SIZE(WS), .NUM_OUT(NO), .NUM_IN(NI)) dut (
      .mclk     (mclk),
      .rst      (rst),
      .bus      (bus),
      .btn      (btn),
      .show_sel (show_sel),
      .show_val (show_val),
      .show_stb (show_stb)
   );

   int            checks   = 0;
   int            failures = 0;
   logic [WS-1:0] rd_exp_q [$];
   logic [WS-1:0] show_exp_q [$];
   logic          get_seen = 1'b0;
   logic [WS-1:0] rd_e;
   logic [WS-1:0] sh_e;

   always #5 mclk = ~mclk;

   task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: a portget accepted at a non-reset edge must show its expected data by the following negedge.
   always @(posedge mclk) get_seen = bus.portget && !rst;

   always @(negedge mclk) begin
      if (get_seen) begin
         if (rd_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL portout: got %h expected no read", bus.portout);
         end else begin
            rd_e = rd_exp_q.pop_front();
            check("portout", bus.portout, rd_e);
         end
      end
      if (show_stb) begin
         if (show_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL show_stb: unexpected pulse, show_val %h expected none", show_val);
         end else begin
            sh_e = show_exp_q.pop_front();
            check("show_val", show_val, sh_e);
         end
      end
   end

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_write(input logic [WS-1:0] addr, input logic [WS-1:0] val);
      bus.portaddr = addr;
      bus.portval  = val;
      bus.portset  = 1'b1;
      step();
      bus.portset  = 1'b0;
   endtask

   task automatic do_read(input logic [WS-1:0] addr, input logic [WS-1:0] exp);
      rd_exp_q.push_back(exp);
      bus.portaddr = addr;
      bus.portget  = 1'b1;
      step();
      bus.portget  = 1'b0;
   endtask

   initial begin
      bus.portaddr = '0;
      bus.portval  = '0;
      bus.portset  = 1'b0;
      bus.portget  = 1'b0;
      repeat (3) step();
      check("reset portout", bus.portout, 16'h0000);
      check("reset show_val", show_val, 16'h0000);
      check("reset show_stb", WS'(show_stb), 16'h0000);
      rst = 1'b0;
      repeat (3) step();

      // Output registers; port 0 is on display, so its write strobes the display.
      show_exp_q.push_back(16'hA5A5);
      do_write(16'd0, 16'hA5A5);
      do_write(16'd1, 16'h1111);
      do_write(16'd3, 16'h3333);
      do_write(16'd2, 16'h1234);
      do_read(16'd2, 16'h1234);
      bus.portaddr = 16'd0;
      repeat (2) step();
      check("portout hold", bus.portout, 16'h1234);
      do_read(16'd0, 16'hA5A5);
      do_read(16'd1, 16'h1111);
      do_read(16'd3, 16'h3333);

      // Out-of-map and read-only addresses.
      do_write(16'd4, 16'hFFFF);
      do_write(16'd5, 16'hFFFF);
      do_write(16'd6, 16'hDEAD);
      do_write(16'hFFFF, 16'hBEEF);
      do_read(16'd4, 16'h0000);
      do_read(16'd5, 16'h0000);
      do_read(16'd6, 16'h0000);
      do_read(16'hFFFF, 16'h0000);
      do_read(16'd2, 16'h1234);

      // Display follows select and register; identical rewrite gives no strobe.
      show_exp_q.push_back(16'h1234);
      show_sel = 2'd2;
      repeat (3) step();
      show_exp_q.push_back(16'hBEEF);
      do_write(16'd2, 16'hBEEF);
      repeat (3) step();
      do_write(16'd2, 16'hBEEF);
      repeat (3) step();
      check("show_val steady", show_val, 16'hBEEF);

      // Button 1 held for 5 cycles.
      btn[1] = 1'b1;
      step();
      step();
      do_read(16'd4, 16'h0002);
      repeat (2) step();
      btn[1] = 1'b0;
      repeat (4) step();
      do_read(16'd4, 16'h0000);
      do_read(16'd5, 16'h0002);
      do_read(16'd5, 16'h0000);

      // Button 0 rise reaches the flag stage together with a clearing read.
      btn[0] = 1'b1;
      step();
      step();
      do_read(16'd5, 16'h0000);
      do_read(16'd5, 16'h0001);
      do_read(16'd5, 16'h0000);
      btn[0] = 1'b0;
      repeat (3) step();

      // Same-cycle read and write of port 1.
      do_write(16'd1, 16'h0001);
      rd_exp_q.push_back(16'h0001);
      bus.portaddr = 16'd1;
      bus.portval  = 16'h0002;
      bus.portset  = 1'b1;
      bus.portget  = 1'b1;
      step();
      bus.portset  = 1'b0;
      bus.portget  = 1'b0;
      do_read(16'd1, 16'h0002);

      // Reset with a write and a read pending.
      bus.portaddr = 16'd0;
      bus.portval  = 16'h00FF;
      bus.portset  = 1'b1;
      bus.portget  = 1'b1;
      rst = 1'b1;
      step();
      bus.portset  = 1'b0;
      bus.portget  = 1'b0;
      step();
      check("rst portout", bus.portout, 16'h0000);
      check("rst show_val", show_val, 16'h0000);
      check("rst show_stb", WS'(show_stb), 16'h0000);
      rst = 1'b0;
      repeat (3) step();
      check("post-rst show_val", show_val, 16'h0000);
      for (int a = 0; a < NO + 2; a++) begin
         do_read(WS'(a), 16'h0000);
      end
      repeat (3) step();

      check("read queue drained", WS'(rd_exp_q.size()), 16'h0000);
      check("show queue drained", WS'(show_exp_q.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/port_bank.md
PORT_BANK -- requirements
Module: port_bank

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, as the width of the port address, data and display.
REQ-002 The block SHALL have parameter NUM_OUT, default 4, as the number of output port registers (range 2..16).
REQ-003 The block SHALL have parameter NUM_IN, default 4, as the number of button input bits (range 1..WORD_SIZE).
REQ-004 The block SHALL have port mclk  input  1  as the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  as the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port portaddr  input  WORD_SIZE  as the CPU port address.
REQ-007 The block SHALL have port portval  input  WORD_SIZE  as the CPU write data.
REQ-008 The block SHALL have port portset  input  1  as the write strobe, valid for one cycle.
REQ-009 The block SHALL have port portget  input  1  as the read strobe, valid for one cycle.
REQ-010 The block SHALL have port portout  output  WORD_SIZE  as the registered read data.
REQ-011 The block SHALL have port btn  input  NUM_IN  as the asynchronous button levels.
REQ-012 The block SHALL have port show_sel  input  clog2(NUM_OUT)  as the display channel select.
REQ-013 The block SHALL have port show_val  output  WORD_SIZE  as the selected channel value for the seven-segment driver.
REQ-014 The block SHALL have port show_stb  output  1  as a one-cycle pulse whenever show_val changes.

Function
REQ-015 Address map: 0..NUM_OUT-1 are output registers (R/W); NUM_OUT is button level status (RO); NUM_OUT+1 is sticky button-press flags (read-to-clear); all other addresses read 0 and ignore writes.
REQ-016 When portset is high and the address is in 0..NUM_OUT-1, the register SHALL take portval at the next edge.
REQ-017 Writes to addresses NUM_OUT and NUM_OUT+1 SHALL be ignored.
REQ-018 When portget is high, portout SHALL present the addressed value at the next edge (latency 1), and SHALL hold that value until the next portget.
REQ-019 When portget and portset both target the same register in one cycle, portout SHALL return the old value, and the register SHALL take the new value.
REQ-020 Each btn bit SHALL pass through a 2-flop synchronizer; status reads return the synchronized levels, zero-extended.
REQ-021 A synchronized 0->1 transition SHALL set the corresponding sticky flag one cycle after it appears at the synchronizer output.
REQ-022 A portget of NUM_OUT+1 SHALL clear all flags that were read, at the same edge that portout loads.
REQ-023 A flag whose rising edge occurs in the same cycle as its clearing read SHALL remain set.
REQ-024 show_val SHALL be registered and equal to register[show_sel] one cycle after show_sel or the selected register changes.
REQ-025 When show_sel >= NUM_OUT, show_val SHALL be 0.
REQ-026 show_stb SHALL pulse for exactly one cycle, aligned with the edge on which show_val takes a differing value.
REQ-027 show_stb SHALL NOT pulse when the selected register is rewritten with an identical value.

Reset
REQ-028 When rst is high at an edge, the block SHALL clear all output registers, flags, synchronizer flops, portout and show_val to 0, and drive show_stb low.
REQ-029 A reset asserted in the same cycle as portset or portget SHALL take priority; no write occurs and portout stays 0.
REQ-030 show_stb SHALL NOT pulse on the first cycle after reset release.

Structure
REQ-031 WORD_SIZE and the address-map offsets (status offset, flag offset) SHALL be defined in the shared parameters.v package.
REQ-032 The per-bit 2-flop synchronizer plus rising-edge detect SHALL be a sub-module named input_sync, instantiated NUM_IN times.
REQ-033 The register file, read mux and display mux SHALL be in port_bank itself; no memory macros are used.

Verification
REQ-034 Scenario 1: write 0x1234 to port 2, then portget port 2 -> portout=0x1234 one cycle after the portget.
REQ-035 Scenario 2: show_sel=2 and write 0xBEEF to port 2 -> show_val=0xBEEF with a single show_stb pulse; write 0xBEEF again -> no pulse.
REQ-036 Scenario 3: pulse btn[1] high for 5 cycles -> status read shows 0x0002 while held; flag read (addr NUM_OUT+1) -> 0x0002, and a second read -> 0x0000.
REQ-037 Scenario 4: btn[0] rising edge reaches the flag stage in the same cycle as a flag read -> the read returns the old flags and bit 0 remains set afterwards.
REQ-038 Scenario 5: same-cycle portget and portset to port 1 (old 0x0001, new 0x0002) -> portout=0x0001, and the next read returns 0x0002.
REQ-039 Scenario 6: assert rst mid-operation with a portset to 0x00FF pending -> all registers read 0, show_val=0, and no show_stb after release.
